// File: rtl/crc_pkg.sv
// Shared types, CAN constants and the single-bit CRC update used by the serial engine.
package crc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_EMIT = 2'd2
    } crc_state_e;

    localparam int unsigned CAN_CRC_W = 15;
    localparam logic [CAN_CRC_W-1:0] CAN_CRC_POLY = 15'h4599;

    // One MSB-first CRC step on a register of 'width' bits (2..32), zero-extended to 32 bits.
    function automatic logic [31:0] crc_step(
        input logic [31:0]  crc,
        input logic         bit_in,
        input logic [31:0]  poly,
        input int unsigned  width
    );
        logic [31:0] mask;
        logic        fb;
        mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        fb   = crc[5'(width - 32'd1)] ^ bit_in;
        return ((crc << 1) ^ (fb ? poly : 32'd0)) & mask;
    endfunction

endpackage

// File: rtl/crc_lfsr_step.sv
// Combinational single-bit CRC register update.
module crc_lfsr_step
    import crc_pkg::*;
#(
    parameter int unsigned         CRC_W = CAN_CRC_W,
    parameter logic [CRC_W-1:0]    POLY  = CRC_W'(CAN_CRC_POLY)
) (
    input  logic [CRC_W-1:0] i_crc,
    input  logic             i_bit,
    output logic [CRC_W-1:0] o_crc_next_c
);

    assign o_crc_next_c = CRC_W'(crc_step(32'(i_crc), i_bit, 32'(POLY), CRC_W));

endmodule

// File: rtl/crc_serial_engine.sv
// Bit-serial CRC engine: absorbs a frame MSB-first, then either shifts the CRC out
// (generate) or absorbs the received CRC field and reports a zero residue (check).
module crc_serial_engine
    import crc_pkg::*;
#(
    parameter int unsigned         CRC_W    = CAN_CRC_W,
    parameter logic [CRC_W-1:0]    POLY     = CRC_W'(CAN_CRC_POLY),
    parameter logic [CRC_W-1:0]    INIT     = '0,
    parameter int unsigned         MAX_BITS = 127,
    localparam int unsigned        CW       = $clog2(MAX_BITS + CRC_W + 1)
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_mode,
    input  logic [CW-1:0]    i_num_bits,
    input  logic             i_bit_valid,
    input  logic             i_bit_in,
    input  logic             i_stuff_bit,
    output logic             o_busy,
    output logic             o_crc_tx,
    output logic             o_crc_tx_valid,
    output logic [CRC_W-1:0] o_crc_out,
    output logic             o_done,
    output logic             o_crc_ok
);

    localparam int unsigned      IW      = $clog2(CRC_W);
    localparam logic [IW-1:0]    IDX_TOP = IW'(CRC_W - 1);

    crc_state_e       r_state;
    logic [CRC_W-1:0] r_crc;
    logic [CW-1:0]    r_cnt;
    logic [IW-1:0]    r_idx;
    logic             r_mode;
    logic             r_busy;
    logic             r_done;
    logic             r_ok;
    logic             r_tx;
    logic             r_tx_valid;

    logic [CRC_W-1:0] w_crc_next;
    logic [CW-1:0]    w_start_cnt;
    logic             w_hashed;

    // Check frames also absorb the received CRC field.
    assign w_start_cnt = i_mode ? (i_num_bits + CW'(CRC_W)) : i_num_bits;
    assign w_hashed    = i_bit_valid & ~i_stuff_bit;

    crc_lfsr_step #(
        .CRC_W (CRC_W),
        .POLY  (POLY)
    ) u_step (
        .i_crc        (r_crc),
        .i_bit        (i_bit_in),
        .o_crc_next_c (w_crc_next)
    );

    // Frame FSM; all outputs registered, crc_tx tracks crc[idx] while emitting.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_crc      <= INIT;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_mode     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ok       <= 1'b0;
            r_tx       <= 1'b0;
            r_tx_valid <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_crc  <= INIT;
                        r_cnt  <= w_start_cnt;
                        r_mode <= i_mode;
                        r_ok   <= 1'b0;
                        if (w_start_cnt != '0) begin
                            r_state <= ST_CALC;
                            r_busy  <= 1'b1;
                        end else if (!i_mode) begin
                            r_state    <= ST_EMIT;
                            r_busy     <= 1'b1;
                            r_idx      <= IDX_TOP;
                            r_tx       <= INIT[CRC_W-1];
                            r_tx_valid <= 1'b1;
                        end else begin
                            r_done <= 1'b1;
                            r_ok   <= (INIT == '0);
                        end
                    end
                end
                ST_CALC: begin
                    if (w_hashed) begin
                        r_crc <= w_crc_next;
                        r_cnt <= r_cnt - CW'(1);
                        if (r_cnt == CW'(1)) begin
                            if (!r_mode) begin
                                r_state    <= ST_EMIT;
                                r_idx      <= IDX_TOP;
                                r_tx       <= w_crc_next[CRC_W-1];
                                r_tx_valid <= 1'b1;
                            end else begin
                                r_state <= ST_IDLE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                                r_ok    <= (w_crc_next == '0);
                            end
                        end
                    end
                end
                ST_EMIT: begin
                    if (i_bit_valid) begin
                        if (r_idx == '0) begin
                            r_state    <= ST_IDLE;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                            r_tx       <= 1'b0;
                            r_tx_valid <= 1'b0;
                        end else begin
                            r_idx <= r_idx - IW'(1);
                            r_tx  <= r_crc[r_idx - IW'(1)];
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_busy         = r_busy;
    assign o_crc_tx       = r_tx;
    assign o_crc_tx_valid = r_tx_valid;
    assign o_crc_out      = r_crc;
    assign o_done         = r_done;
    assign o_crc_ok       = r_ok;

endmodule

// File: doc/crc_serial_engine.md
# crc_serial_engine

Parametrised bit-serial CRC engine for the CAN controller. It is the successor to the fixed 16-bit, fixed 48-bit LFSR. The block takes destuffed or raw frame bits MSB-first under a valid strobe and skips flagged stuff bits. Frame length is set per start, not fixed. In generate mode it computes the CRC and then serialises it out. In check mode it absorbs the received CRC field and reports a pass/fail. The default configuration is CAN CRC-15; the TX path and the RX path each instantiate one.

## Interface
Parameters:
- CRC_W, 15, CRC register width (2..32)
- POLY, 15'h4599, generator polynomial without the implicit x^CRC_W term
- INIT, 0, register value loaded on start
- MAX_BITS, 127, largest num_bits accepted; CW = $clog2(MAX_BITS+CRC_W+1)

Ports:
- clock  in  1  single clock; all logic on posedge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- start  in  1  begin a frame; sampled only in IDLE
- mode  in  1  sampled with start; 0 = generate, 1 = check
- num_bits  in  CW  data bits to absorb, excluding CRC and stuff bits; sampled with start
- bit_valid  in  1  bit_in (and stuff_bit) valid this cycle
- bit_in  in  1  serial data, MSB first
- stuff_bit  in  1  qualifies bit_valid; the bit is consumed but not hashed or counted
- busy  out  1  high from the cycle after an accepted start until done
- crc_tx  out  1  generate mode: current CRC bit being emitted, MSB first
- crc_tx_valid  out  1  high while in EMIT
- crc_out  out  CRC_W  register contents; holds its last value in IDLE
- done  out  1  one-cycle pulse at end of frame
- crc_ok  out  1  check mode: residue == 0, registered with done and held until the next start

## Operation
- States: IDLE, CALC, EMIT.
- IDLE:
  - On start, load crc = INIT.
  - Generate mode: cnt = num_bits. Check mode: cnt = num_bits + CRC_W.
  - Clear crc_ok.
  - Go to CALC if cnt != 0. Otherwise go to EMIT (generate) or assert done with crc_ok = (INIT == 0) (check).
- CALC, on a hashed bit (bit_valid && !stuff_bit):
  - fb = crc[CRC_W-1] ^ bit_in
  - crc <= {crc[CRC_W-2:0], 0} ^ (fb ? POLY : 0)
  - cnt <= cnt - 1
- CALC, on the last hashed bit (cnt == 1):
  - Generate mode goes to EMIT with idx = CRC_W-1.
  - Check mode goes to IDLE, pulses done, and sets crc_ok = (next crc == 0).
- Stuff bits and cycles with bit_valid low leave crc and cnt unchanged.
- EMIT:
  - crc_tx = crc[idx] combinationally; crc_tx_valid = 1.
  - Each bit_valid cycle accepts the presented bit and decrements idx. bit_in and stuff_bit are ignored; the upstream stuffer owns stuffing of the CRC field.
  - When idx == 0 is accepted, go to IDLE and pulse done.
  - crc is not modified in EMIT.
- start while busy is ignored, with no effect on the current frame.
- Reset mid-frame: next state IDLE, crc = INIT, cnt = 0, busy/done/crc_ok/crc_tx_valid = 0. Any partial frame is discarded.
- Reset values: busy 0, done 0, crc_ok 0, crc_tx_valid 0, crc_tx 0, crc_out INIT.
- num_bits > MAX_BITS: undefined; the verification bench must not drive it.

## Timing
- start accepted at edge N: busy = 1 from N+1. The first bit is sampled at N+1 at the earliest.
- CALC throughput: one hashed bit per clock when bit_valid is held high.
- done asserts in the cycle after the edge that consumed the final bit. crc_out and crc_ok are valid in that same cycle.
- Generate-mode latency from start with continuous bit_valid: num_bits + CRC_W + 1 cycles to done.
- done and busy are never high together; busy falls in the cycle done rises.
- start in the same cycle as done: accepted, because the state is already IDLE.

## Structure
- Shared package crc_pkg holds:
  - state enum (IDLE, CALC, EMIT)
  - CAN constants CAN_CRC_W = 15, CAN_CRC_POLY = 15'h4599
  - helper function crc_step(crc, bit, poly) used by the RTL and by the bench model
- One sub-module: crc_lfsr_step, a combinational single-bit update, parametrised by CRC_W and POLY. It is reused later for a parallel variant.

## Test plan
- Generate, default parameters, num_bits = 2, bits 1,0 -> crc_out = 15'h4EAB at done; EMIT shifts out 100111010101011.
- Check, num_bits = 2, bits 1,0 followed by the 15 bits of 15'h4EAB -> done after 17 hashed bits, crc_ok = 1, crc_out = 0.
- Same as the check case with one CRC bit flipped -> crc_ok = 0, crc_out != 0.
- Generate 1,0 with a stuff_bit = 1 cycle inserted between them, plus random bit_valid gaps -> crc_out = 15'h4EAB, cycle count to done increases exactly by the gaps.
- Assert reset in the middle of CALC, then restart with bits 1,0 -> outputs are 0 the cycle after reset; the second frame yields 15'h4EAB; start pulses during busy are ignored.
- num_bits = 0 in generate mode -> EMIT directly, emits INIT; CRC_W = 16, POLY = 16'h1021, INIT = 16'hFFFF with random frames -> matches the crc_step reference model.
